// File: rtl/pipe_skid_register.sv
// pipe_skid_register
//   Parametrised pipeline-stage register with a valid/ready handshake,
//   optional 2-entry skid buffer, synchronous flush with bubble insertion
//   and a saturating count of entries discarded by flush.
//
//   Ports
//     clk            : clock, all state updates on the rising edge
//     reset_n        : synchronous active-low reset
//     flush          : discard every held entry (and any push) this cycle
//     in_valid       : upstream presents an entry
//     in_ready       : this stage accepts an entry this cycle
//     in_data        : upstream data payload (never cleared)
//     in_ctrl        : upstream control payload (reads zero when empty)
//     out_valid      : head entry available downstream
//     out_ready      : downstream consumes the head entry this cycle
//     out_data       : head-entry data
//     out_ctrl       : head-entry control, all-zero when out_valid=0
//     occupancy      : number of held entries (0..2)
//     flush_drop_cnt : saturating count of valid entries dropped by flush
module pipe_skid_register #(
    parameter int DATA_W  = 64,
    parameter int CTRL_W  = 8,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_drop_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              push;
    logic              pop;
    logic              load_in_main;
    logic              load_skid_main;
    logic              load_in_skid;

    // Saturating add of the current occupancy onto the drop counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                  input logic [1:0]       inc);
        logic [CNT_W+1:0] sum;
        sum = {2'b00, cnt} + {{CNT_W{1'b0}}, inc};
        if (sum > {2'b00, {CNT_W{1'b1}}})
            return {CNT_W{1'b1}};
        return sum[CNT_W-1:0];
    endfunction

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // With the skid buffer, in_ready depends on state only, which breaks the
    // ready path from downstream. Without it, a consumed head frees the slot
    // in the same cycle.
    generate
        if (SKID_EN != 0) begin : g_skid
            assign in_ready = (state != TWO) & reset_n;
        end else begin : g_noskid
            assign in_ready = (~out_valid | out_ready) & reset_n;
        end
    endgenerate

    always_comb begin
        state_nx       = state;
        load_in_main   = 1'b0;
        load_skid_main = 1'b0;
        load_in_skid   = 1'b0;
        unique case (state)
            EMPTY: begin
                if (push) begin
                    state_nx     = ONE;
                    load_in_main = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_in_main = 1'b1;
                end else if (push && (SKID_EN != 0)) begin
                    state_nx     = TWO;
                    load_in_skid = 1'b1;
                end else if (pop) begin
                    state_nx = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_nx       = ONE;
                    load_skid_main = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
        // Flush overrides any handshake: bubble in, push discarded.
        if (flush) begin
            state_nx       = EMPTY;
            load_in_main   = 1'b0;
            load_skid_main = 1'b0;
            load_in_skid   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= EMPTY;
            main_ctrl      <= '0;
            skid_ctrl      <= '0;
            flush_drop_cnt <= '0;
        end else begin
            state <= state_nx;
            if (flush) begin
                main_ctrl      <= '0;
                skid_ctrl      <= '0;
                flush_drop_cnt <= sat_add(flush_drop_cnt, occupancy);
            end else begin
                if (load_in_main)
                    main_ctrl <= in_ctrl;
                else if (load_skid_main)
                    main_ctrl <= skid_ctrl;
                if (load_in_skid)
                    skid_ctrl <= in_ctrl;
            end
        end
    end

    // Head data has a defined reset value; it is otherwise never cleared.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            main_data <= '0;
        end else if (load_in_main) begin
            main_data <= in_data;
        end else if (load_skid_main) begin
            main_data <= skid_data;
        end
    end

    always_ff @(posedge clk) begin
        if (load_in_skid)
            skid_data <= in_data;
    end

    assign occupancy = state;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign out_ctrl  = out_valid ? main_ctrl : '0;

endmodule

// File: doc/pipe_skid_register.md
Name: pipe_skid_register

Overview:
- Generic, parametrised pipeline-stage register that replaces fixed, always-latching stage registers such as MEM/WB.
- Adds a valid/ready handshake, back-pressure through an optional 2-entry skid buffer, synchronous flush with bubble insertion, and a flushed-entry counter.
- Placed between any two core pipeline stages (IF/ID through MEM/WB). Payload is split into data bits, which are not cleared, and control bits (reg_write, valid, csr_we, flags…), which are zeroed whenever the stage holds no valid entry.

Parameters:
- DATA_W, 64: payload data width (XLEN/FLEN-sized fields concatenated by the instantiating stage).
- CTRL_W, 8: control-field width; these bits read zero whenever out_valid=0.
- SKID_EN, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 8: width of the flush-drop counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  discard all held entries this cycle.
- in_valid  in  1  upstream stage presents an entry.
- in_ready  out  1  this stage accepts an entry this cycle.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  downstream entry available.
- out_ready  in  1  downstream consumes the entry this cycle.
- out_data  out  DATA_W  head-entry data.
- out_ctrl  out  CTRL_W  head-entry control; all-zero when out_valid=0.
- occupancy  out  2  number of held entries (0..2).
- flush_drop_cnt  out  CNT_W  saturating count of valid entries discarded by flush.

Behaviour:
- Definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: main register (head) and skid register; state EMPTY(0), ONE(1), TWO(2) is mirrored on occupancy.
- Reset:
  - Synchronous; reset_n low at a rising edge sets state=EMPTY, main/skid ctrl=0, out_valid=0, occupancy=0, flush_drop_cnt=0.
  - out_data reset value is 0.
  - in_ready=0 while reset_n is low.
  - Reset mid-transfer discards all entries; the drop counter is not incremented.
- Priority: reset > flush > push/pop.
- Flush:
  - Next state EMPTY; all ctrl registers cleared; a push in the same cycle is discarded.
  - flush_drop_cnt += occupancy, saturating at all-ones.
  - Data registers hold their values.
- SKID_EN=1 transitions:
  - EMPTY: push -> ONE, main<=in.
  - ONE, push&pop -> ONE, main<=in.
  - ONE, push&!pop -> TWO, skid<=in.
  - ONE, !push&pop -> EMPTY.
  - TWO: in_ready=0; pop -> ONE, main<=skid; otherwise hold.
  - in_ready = (state!=TWO) & reset_n. It is a registered function of state only and has no combinational path from out_ready.
- SKID_EN=0 transitions:
  - TWO is unreachable; occupancy ≤ 1.
  - in_ready = (!out_valid | out_ready) & reset_n.
  - push loads main: state ONE. pop without push: EMPTY.
- Outputs and latency:
  - out_valid = (state!=EMPTY).
  - out_data/out_ctrl come from main; out_ctrl is forced to 0 when EMPTY.
  - Latency is 1 cycle from push to out_valid, with no bubbles under continuous flow (throughput 1/cycle).
- Ordering: strict FIFO. An entry in skid never overtakes main. No entry is duplicated or lost except by flush or reset.
- Stall: out_ready=0 holds out_data/out_ctrl stable while out_valid=1.

Test Plan:
- Stream with SKID_EN=1: reset, then in_valid=1 with data 0x1,0x2,0x3… and out_ready=1 -> out_valid from cycle 1; outputs 0x1,0x2,0x3 on consecutive cycles; occupancy stays 1.
- Back-pressure: push 0xA then 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data holds 0xA. Raise out_ready -> 0xA then 0xB in order, then occupancy=0.
- Flush while full: occupancy=2, flush=1 together with in_valid=1 carrying 0xC -> next cycle out_valid=0, out_ctrl=0, occupancy=0, flush_drop_cnt=2; 0xC never appears at the output.
- Counter saturation: CNT_W=2, perform four flushes at occupancy=2 -> flush_drop_cnt=3 and it stays 3.
- SKID_EN=0: out_valid=1 with out_ready=0 -> in_ready=0. Set out_ready=1 with in_valid=1 carrying 0x5 -> in_ready=1 in the same cycle and out_data=0x5 next cycle.
- Mid-operation reset: occupancy=2, reset_n=0 for one edge -> occupancy=0, out_valid=0, flush_drop_cnt=0. in_ready=0 during reset and 1 on the first cycle after.
